// File: rtl/dm_be_pkg.sv
// Byte-enable lane encodings shared by the data-memory store placer and load return path.
package dm_be_pkg;

  localparam int unsigned BE_W = 4;

  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;
  localparam logic [BE_W-1:0] BE_NONE = 4'b0000;
  localparam logic [BE_W-1:0] BE_H0   = 4'b0011;
  localparam logic [BE_W-1:0] BE_H1   = 4'b1100;
  localparam logic [BE_W-1:0] BE_B0   = 4'b0001;
  localparam logic [BE_W-1:0] BE_B1   = 4'b0010;
  localparam logic [BE_W-1:0] BE_B2   = 4'b0100;
  localparam logic [BE_W-1:0] BE_B3   = 4'b1000;

  localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/dm_load_lane_sel.sv
// Load lane selector: picks the byte/halfword/word named by the lane mask and
// zero- or sign-extends it to 32 bits; unrecognised masks yield zero with err set.
module dm_load_lane_sel
  import dm_be_pkg::*;
(
  input  logic [31:0]     data,
  input  logic [BE_W-1:0] be,
  input  logic            sign,
  output logic [31:0]     ext_data,
  output logic            err
);

  logic [7:0]  byte_f;
  logic [15:0] half_f;
  logic        is_byte;
  logic        is_half;

  always_comb begin
    ext_data = '0;
    err      = 1'b0;
    byte_f   = '0;
    half_f   = '0;
    is_byte  = 1'b0;
    is_half  = 1'b0;

    case (be)
      BE_WORD, BE_NONE: ext_data = data;
      BE_H0: begin half_f = data[15:0];  is_half = 1'b1; end
      BE_H1: begin half_f = data[31:16]; is_half = 1'b1; end
      BE_B0: begin byte_f = data[7:0];   is_byte = 1'b1; end
      BE_B1: begin byte_f = data[15:8];  is_byte = 1'b1; end
      BE_B2: begin byte_f = data[23:16]; is_byte = 1'b1; end
      BE_B3: begin byte_f = data[31:24]; is_byte = 1'b1; end
      default: err = 1'b1;
    endcase

    // Sub-word loads extend from the top bit of the field only for signed loads.
    if (is_byte) ext_data = {{24{sign & byte_f[7]}}, byte_f};
    if (is_half) ext_data = {{16{sign & half_f[15]}}, half_f};
  end

endmodule

// File: rtl/dm_load_ret_buf.sv
// Load-return buffer: extracts/extends the loaded lane and queues it with its
// destination register in a 2-entry valid/ready FIFO. Optional DM_LOAD_ERR_CNT_EN adds err_cnt.
module dm_load_ret_buf
  import dm_be_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned RW    = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [BE_W-1:0] in_be,
  input  logic            in_sign,
  input  logic [RW-1:0]   in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [RW-1:0]   out_rd,
  output logic            out_err
`ifdef DM_LOAD_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic [CW-1:0]  count;
  logic [DW-1:0]  data_q [DEPTH];
  logic [RW-1:0]  rd_q   [DEPTH];
  logic [DEPTH-1:0] err_q;

  logic [31:0] ext_data;
  logic        ext_err;
  logic        push;
  logic        pop;

  dm_load_lane_sel u_lane_sel (
    .data     (in_data),
    .be       (in_be),
    .sign     (in_sign),
    .ext_data (ext_data),
    .err      (ext_err)
  );

  // Handshake flags come from the stored count only, so no in-to-out combinational path exists.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data = data_q[rptr];
  assign out_rd   = rd_q[rptr];
  assign out_err  = err_q[rptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      err_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
      end
    end else if (flush) begin
      // Entry payloads are left as-is; only occupancy and pointers are cleared.
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        data_q[wptr] <= DW'(ext_data);
        rd_q[wptr]   <= in_rd;
        err_q[wptr]  <= ext_err;
        wptr         <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef DM_LOAD_ERR_CNT_EN
  // Counts accepted illegal-mask loads; survives flush and saturates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (!flush && push && ext_err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dm_load_ret_buf.sv
// Bench for dm_load_ret_buf: directed cases plus random traffic against a queue model.
// Build with DM_LOAD_ERR_CNT_EN defined to also check err_cnt.
module tb_dm_load_ret_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_be;
  logic        in_sign;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_err;
`ifdef DM_LOAD_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    logic        e;
  } ent_t;

  ent_t q[$];
  int   model_errcnt = 0;
  bit   last_push;

  always #5 clk = ~clk;

  dm_load_ret_buf dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_be     (in_be),
    .in_sign   (in_sign),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .out_err   (out_err)
`ifdef DM_LOAD_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference extraction: lane offset/width from the mask, then shift, mask and extend.
  function automatic ent_t ref_ext(input logic [31:0] data, input logic [3:0] be,
                                   input logic sign, input logic [4:0] rd);
    ent_t r;
    int off;
    int bits;
    logic [31:0] m;
    logic [31:0] v;
    r.rd = rd;
    r.e  = 1'b0;
    off  = 0;
    bits = 32;
    case (be)
      4'hF, 4'h0: bits = 32;
      4'h3: begin off = 0;  bits = 16; end
      4'hC: begin off = 16; bits = 16; end
      4'h1: begin off = 0;  bits = 8;  end
      4'h2: begin off = 8;  bits = 8;  end
      4'h4: begin off = 16; bits = 8;  end
      4'h8: begin off = 24; bits = 8;  end
      default: r.e = 1'b1;
    endcase
    if (r.e) begin
      r.d = 32'h0;
    end else if (bits == 32) begin
      r.d = data;
    end else begin
      m = (32'h1 << bits) - 32'h1;
      v = (data >> off) & m;
      if (sign && v[bits-1]) v = v | ~m;
      r.d = v;
    end
    return r;
  endfunction

  // Check visible state against the model, advance one edge, update the model.
  task automatic tick();
    bit push;
    bit pop;
    ent_t n;
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("head_data", out_data, q[0].d);
      chk("head_rd", 32'(out_rd), 32'(q[0].rd));
      chk("head_err", 32'(out_err), 32'(q[0].e));
    end
`ifdef DM_LOAD_ERR_CNT_EN
    chk("err_cnt", 32'(err_cnt), 32'(model_errcnt));
`endif
    push = in_valid && (q.size() < 2);
    pop  = out_ready && (q.size() > 0);
    n    = ref_ext(in_data, in_be, in_sign, in_rd);
    @(posedge clk);
    #1;
    last_push = 1'b0;
    if (!reset) begin
      q.delete();
      model_errcnt = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(n);
        last_push = 1'b1;
        if (n.e && model_errcnt < 255) model_errcnt++;
      end
    end
  endtask

  task automatic push1(input logic [31:0] d, input logic [3:0] be, input logic s,
                       input logic [4:0] rd);
    in_data  = d;
    in_be    = be;
    in_sign  = s;
    in_rd    = rd;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 8 && q.size() > 0; i++) tick();
    out_ready = 1'b0;
    chk("drain_empty", 32'(out_valid), 32'h0);
  endtask

  initial begin
    logic [3:0] legal [8];
    legal = '{4'hF, 4'h0, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_be = '0; in_sign = 1'b0; in_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_rd", 32'(out_rd), 32'h0);
    chk("rst_out_err", 32'(out_err), 32'h0);
    reset = 1'b1;
    tick();

    // Illegal masks first so the error count is known exactly.
    push1(32'hDEAD_BEEF, 4'b0101, 1'b0, 5'd4);
    push1(32'hCAFE_F00D, 4'b0110, 1'b1, 5'd5);
    chk("illegal_data0", out_data, 32'h0);
    chk("illegal_err0", 32'(out_err), 32'h1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("illegal_data1", out_data, 32'h0);
    chk("illegal_err1", 32'(out_err), 32'h1);
`ifdef DM_LOAD_ERR_CNT_EN
    chk("err_cnt_two", 32'(err_cnt), 32'd2);
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_clears", 32'(out_valid), 32'h0);
`ifdef DM_LOAD_ERR_CNT_EN
    chk("err_cnt_after_flush", 32'(err_cnt), 32'd2);
`endif

    push1(32'h80FF_7F01, 4'b1000, 1'b1, 5'd7);
    chk("sb_valid", 32'(out_valid), 32'h1);
    chk("sb_data", out_data, 32'hFFFF_FF80);
    chk("sb_err", 32'(out_err), 32'h0);
    drain();
    push1(32'h80FF_7F01, 4'b1000, 1'b0, 5'd8);
    chk("ub_data", out_data, 32'h0000_0080);
    drain();
    push1(32'h8001_1234, 4'b1100, 1'b1, 5'd9);
    chk("sh_data", out_data, 32'hFFFF_8001);
    drain();
    push1(32'h8001_1234, 4'b0011, 1'b1, 5'd10);
    chk("uh_data", out_data, 32'h0000_1234);
    drain();

    // Backpressure: three loads against a stalled writeback.
    in_data = 32'h1111_2222; in_be = 4'hF; in_sign = 1'b0;
    in_valid = 1'b1;
    in_rd = 5'd1; tick();
    in_rd = 5'd2; tick();
    in_rd = 5'd3; tick();
    chk("bp_full", 32'(in_ready), 32'h0);
    chk("bp_head1", 32'(out_rd), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_ready_rise", 32'(in_ready), 32'h1);
    chk("bp_head2", 32'(out_rd), 32'd2);
    tick();
    chk("bp_head3", 32'(out_rd), 32'd3);
    chk("bp_valid3", 32'(out_valid), 32'h1);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("bp_empty", 32'(out_valid), 32'h0);

    // Flush with a full buffer and a concurrent push.
    push1(32'h0000_0011, 4'hF, 1'b0, 5'd11);
    push1(32'h0000_0012, 4'hF, 1'b0, 5'd12);
    in_valid = 1'b1; in_rd = 5'd13; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_full_valid", 32'(out_valid), 32'h0);
    chk("flush_full_ready", 32'(in_ready), 32'h1);
    tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_data   = $urandom;
      in_be     = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 7)] : 4'($urandom);
      in_sign   = 1'($urandom);
      in_rd     = 5'($urandom);
      tick();
    end
    flush = 1'b0;

    // Reset in the middle of a transfer.
    in_valid = 1'b1; out_ready = 1'b0; in_be = 4'hF; in_data = 32'h1234_5678;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; in_valid = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_ready", 32'(in_ready), 32'h1);
    chk("mid_rst_data", out_data, 32'h0);
`ifdef DM_LOAD_ERR_CNT_EN
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'h0);
`endif
    out_ready = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
